// File: rtl/fifo_ctrl_param.sv
// rtl/fifo_ctrl_param.sv - FIFO pointer/occupancy controller; almost flags built only with FIFO_CTRL_ALMOST_EN
module fifo_ctrl_param #(
  parameter int addr_width = 5,
  parameter int af_level   = (2 ** addr_width) - 4,
  parameter int ae_level   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  err_clr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [addr_width-1:0] wr_ptr,
  output logic [addr_width-1:0] rd_ptr,
  output logic [addr_width:0]   count,
  output logic                  emp,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** addr_width;
  localparam logic [addr_width:0] DEPTH_V = DEPTH[addr_width:0];

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [addr_width:0] count_q, count_d;
  logic [addr_width:0] wr_ptr_q, rd_ptr_q;
  logic                overflow_q, underflow_q;
  logic                ovf_set, udf_set;

  // Status flags come straight from the encoded occupancy state
  assign emp   = (state_q == S_EMPTY);
  assign full  = (state_q == S_FULL);
  assign count = count_q;

  // Strobes gate requests against current status; a simultaneous rd/wr on
  // an empty (full) FIFO naturally degrades to write-only (read-only)
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~emp;

  assign wr_ptr = wr_ptr_q[addr_width-1:0];
  assign rd_ptr = rd_ptr_q[addr_width-1:0];

  // A rejected request is an error only if the other side did not move
  assign ovf_set = wr & full & ~rd_en;
  assign udf_set = rd & emp & ~wr_en;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Next occupancy and the state it falls into
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (count_d == '0)
      state_d = S_EMPTY;
    else if (count_d == DEPTH_V)
      state_d = S_FULL;
    else
      state_d = S_PARTIAL;
  end

  // Occupancy state register; reset discards everything held
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Wrapping pointers advance only on accepted strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set)      overflow_q <= 1'b1;
      else if (err_clr) overflow_q <= 1'b0;
      if (udf_set)      underflow_q <= 1'b1;
      else if (err_clr) underflow_q <= 1'b0;
    end
  end

`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [addr_width:0] AF_V = af_level[addr_width:0];
  localparam logic [addr_width:0] AE_V = ae_level[addr_width:0];
  assign almost_full  = (count_q >= AF_V);
  assign almost_empty = (count_q <= AE_V);
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb/tb_fifo_ctrl_param.sv - scoreboard bench for fifo_ctrl_param (addr_width=3, af=6, ae=1)
module tb_fifo_ctrl_param;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst, wr, rd, err_clr;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          emp, full, almost_empty, almost_full, overflow, underflow;

  fifo_ctrl_param #(.addr_width(AW), .af_level(AF), .ae_level(AE)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .err_clr(err_clr),
    .wr_en(wr_en), .rd_en(rd_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .count(count), .emp(emp), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wr_en, rd_en, wptr, rptr, cnt, emp, full, af, ae, ovf, udf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: unbounded transfer tallies and an occupancy integer
  int m_wr_total, m_rd_total, m_cnt, m_ovf, m_udf;
  bit armed = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wr_en",        int'(wr_en),        e.wr_en);
      chk("rd_en",        int'(rd_en),        e.rd_en);
      chk("wr_ptr",       int'(wr_ptr),       e.wptr);
      chk("rd_ptr",       int'(rd_ptr),       e.rptr);
      chk("count",        int'(count),        e.cnt);
      chk("emp",          int'(emp),          e.emp);
      chk("full",         int'(full),         e.full);
      chk("almost_full",  int'(almost_full),  e.af);
      chk("almost_empty", int'(almost_empty), e.ae);
      chk("overflow",     int'(overflow),     e.ovf);
      chk("underflow",    int'(underflow),    e.udf);
    end
  end

  // One clock of stimulus: predict outputs for this cycle, then apply the edge
  task automatic step(input bit r, input bit w, input bit d, input bit c);
    exp_t e;
    int   we, re;
    rst = r; wr = w; rd = d; err_clr = c;
    we = (w && m_cnt != DEPTH) ? 1 : 0;
    re = (d && m_cnt != 0) ? 1 : 0;
    if (armed) begin
      e.wr_en = we;
      e.rd_en = re;
      e.wptr  = m_wr_total % DEPTH;
      e.rptr  = m_rd_total % DEPTH;
      e.cnt   = m_cnt;
      e.emp   = (m_cnt == 0) ? 1 : 0;
      e.full  = (m_cnt == DEPTH) ? 1 : 0;
`ifdef FIFO_CTRL_ALMOST_EN
      e.af    = (m_cnt >= AF) ? 1 : 0;
      e.ae    = (m_cnt <= AE) ? 1 : 0;
`else
      e.af    = 0;
      e.ae    = 0;
`endif
      e.ovf   = m_ovf;
      e.udf   = m_udf;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_wr_total = 0; m_rd_total = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
      armed = 1;
    end else begin
      if (w && m_cnt == DEPTH && re == 0) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (d && m_cnt == 0 && we == 0) m_udf = 1;
      else if (c) m_udf = 0;
      m_wr_total += we;
      m_rd_total += re;
      m_cnt      += we - re;
    end
    #1;
  endtask

  initial begin
    int pw, pr;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
    #1;
    step(1, 0, 0, 0);
    // Fill from empty; one extra write on full overflows, then clear it
    repeat (8) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    // Simultaneous request on full performs read only
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    // Overflow again, drain to 5, then reset mid-operation
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    // Underflow on empty; set during clear keeps the flag
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    // Simultaneous request on empty performs write only
    step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    // Hold occupancy at 4 with 10 concurrent read/writes
    repeat (4) step(0, 1, 0, 0);
    repeat (10) step(0, 1, 1, 0);
    repeat (4) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // Randomized phases with shifting write/read bias
    for (int ph = 0; ph < 8; ph++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 80; i++) begin
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < pw),
             ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 19) == 0));
      end
    end
    step(0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_param.md
FIFO_CTRL_PARAM -- requirements
Module: fifo_ctrl_param

Interface
REQ-001 SHALL have parameter addr_width, default 5, meaning RAM address bits; depth DEPTH = 2**addr_width entries.
REQ-002 SHALL have parameter af_level, default DEPTH-4, meaning almost_full threshold in entries.
REQ-003 SHALL have parameter ae_level, default 4, meaning almost_empty threshold in entries.
REQ-004 SHALL have ports: clk  in  1  controller clock; single clock domain, rising edge.
REQ-005 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports: wr  in  1  external write request.
REQ-007 SHALL have ports: rd  in  1  external read request.
REQ-008 SHALL have ports: err_clr  in  1  clears sticky overflow/underflow.
REQ-009 SHALL have ports: wr_en, rd_en  out  1 each  write/read strobes to RAM.
REQ-010 SHALL have ports: wr_ptr, rd_ptr  out  addr_width each  RAM addresses.
REQ-011 SHALL have ports: count  out  addr_width+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have ports: emp, full, almost_empty, almost_full  out  1 each  status flags.
REQ-013 SHALL have ports: overflow, underflow  out  1 each  sticky error flags.

Function
REQ-014 SHALL drive wr_en = wr & ~full and rd_en = rd & ~emp combinationally, same cycle.
REQ-015 SHALL increment wr_ptr by 1 at each clk edge with wr_en=1, modulo DEPTH; rd_ptr likewise with rd_en=1.
REQ-016 SHALL keep internal wrap bits (addr_width+1 bit pointers); wr_ptr/rd_ptr are the low addr_width bits.
REQ-017 SHALL update count: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-018 SHALL derive emp = (count==0) and full = (count==DEPTH), both valid the cycle after the causing edge.
REQ-019 SHALL assert almost_full when count >= af_level, almost_empty when count <= ae_level.
REQ-020 SHALL, with wr=1 and rd=1 while emp=1, perform write only; while full=1, perform read only; otherwise both, count unchanged.
REQ-021 SHALL set overflow at the edge after a cycle with wr=1 and full=1 (and rd_en=0); underflow at the edge after rd=1 and emp=1 (and wr_en=0).
REQ-022 SHALL hold overflow/underflow until err_clr=1 or rst=1; a set event coincident with err_clr SHALL win (flag stays 1).
REQ-023 SHALL not move pointers or count on rejected requests.
REQ-024 SHALL implement count/flags as one encoded state: EMPTY (count=0), PARTIAL, FULL (count=DEPTH); transitions only via REQ-017.

Reset
REQ-025 SHALL, on clk edge with rst=1, set wr_ptr=0, rd_ptr=0, count=0, emp=1, full=0, overflow=0, underflow=0.
REQ-026 SHALL give rst priority over wr, rd and err_clr; reset mid-operation discards occupancy.
REQ-027 SHALL, during rst=1, drive wr_en/rd_en per REQ-014 but ignore them for pointer updates.

Configuration
REQ-028 SHALL compile almost_full/almost_empty logic only when macro FIFO_CTRL_ALMOST_EN is defined.
REQ-029 SHALL, without FIFO_CTRL_ALMOST_EN, tie almost_full=0 and almost_empty=0; ports remain; all other behaviour identical.

Verification (addr_width=3, DEPTH=8, af_level=6, ae_level=1, macro defined)
REQ-030 SHALL cover: rst, then 8 cycles wr=1 -> wr_ptr 0..7 then 0, count=8, full=1, almost_full from count=6, emp=0 after first write.
REQ-031 SHALL cover: full, wr=1 one cycle -> wr_en=0, wr_ptr unchanged, overflow=1 next cycle; err_clr=1 -> overflow=0.
REQ-032 SHALL cover: empty after rst, rd=1 -> rd_en=0, rd_ptr=0, underflow=1 next cycle, count stays 0.
REQ-033 SHALL cover: count=4, wr=1 rd=1 for 10 cycles -> count stays 4, both pointers advance 10 mod 8 = 2 from start.
REQ-034 SHALL cover: count=5 with overflow=1, rst=1 one cycle -> pointers 0, count 0, emp=1, overflow=0 next cycle.
REQ-035 SHALL cover: without FIFO_CTRL_ALMOST_EN, fill to 8 -> almost_full=0, almost_empty=0 throughout, full=1.
